// File: rtl/pblaze_regfile_if.sv
// Picoblaze register-file window: N_REGS host->PB bytes, N_REGS PB->host bytes,
// host strobes, and (with PBLAZE_REGFILE_IRQ_EN defined) change detect + maskable interrupt.
module pblaze_regfile_if #(
  parameter int                  N_REGS    = 4,
  parameter logic [7:0]          BASE_ADDR = 8'h00,
  parameter logic [8*N_REGS-1:0] OUT_RESET = {N_REGS{8'h00}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Wr_Strobe,
  input  logic                  Rd_Strobe,
  input  logic [7:0]            AddrIn,
  input  logic [7:0]            DataIn,
  output logic [7:0]            DataOut,
  output logic                  Interrupt,
  input  logic                  Interrupt_Ack,
  input  logic [8*N_REGS-1:0]   host_in,
  output logic [8*N_REGS-1:0]   host_out,
  output logic [N_REGS-1:0]     host_out_stb,
  output logic [N_REGS-1:0]     host_in_rd
);

  localparam int              AW       = $clog2(N_REGS) + 1;
  localparam logic [AW-1:0]   OFF_CHG  = AW'(N_REGS);
  localparam logic [AW-1:0]   OFF_MASK = AW'(N_REGS + 1);

  logic            hit;
  logic [AW-1:0]   off;
  logic            wr_hit;
  logic            rd_hit;
  logic [N_REGS-1:0] sel;
  logic [7:0]      rd_data;
  logic [7:0]      chg_rd;
  logic [7:0]      mask_rd;

  assign hit    = (AddrIn[7:AW] == BASE_ADDR[7:AW]);
  assign off    = AddrIn[AW-1:0];
  assign wr_hit = Wr_Strobe & hit;
  assign rd_hit = Rd_Strobe & hit;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REGS; i++) sel[i] = (off == AW'(i));
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < N_REGS; i++)
      if (sel[i]) rd_data = host_in[8*i +: 8];
    if (off == OFF_CHG)  rd_data = chg_rd;
    if (off == OFF_MASK) rd_data = mask_rd;
  end

  // Strobe semantics: host_out_stb[i] / host_in_rd[i] are single-cycle pulses with no
  // back-pressure, registered so they coincide with the new host_out byte / DataOut value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DataOut      <= 8'h00;
      host_out     <= OUT_RESET;
      host_out_stb <= '0;
      host_in_rd   <= '0;
    end else begin
      if (hit) DataOut <= rd_data;
      host_in_rd   <= rd_hit ? sel : '0;
      host_out_stb <= wr_hit ? sel : '0;
      for (int i = 0; i < N_REGS; i++)
        if (wr_hit && sel[i]) host_out[8*i +: 8] <= DataIn;
    end
  end

`ifdef PBLAZE_REGFILE_IRQ_EN
  logic [8*N_REGS-1:0] prev;
  logic                primed;
  logic [N_REGS-1:0]   chg;
  logic [N_REGS-1:0]   mask;
  logic [N_REGS-1:0]   diff;
  logic [N_REGS-1:0]   clr;
  logic [N_REGS-1:0]   chg_nxt;
  logic [N_REGS-1:0]   mask_nxt;
  logic                irq_event;
  logic                irq_q;

  always_comb begin
    diff = '0;
    for (int i = 0; i < N_REGS; i++)
      diff[i] = primed && (host_in[8*i +: 8] != prev[8*i +: 8]);
    clr      = (wr_hit && off == OFF_CHG) ? DataIn[N_REGS-1:0] : '0;
    // A set in the same cycle as a W1C clear wins.
    chg_nxt  = (chg & ~clr) | diff;
    mask_nxt = (wr_hit && off == OFF_MASK) ? DataIn[N_REGS-1:0] : mask;
    // An event is a masked flag rising, whether from a new change or from unmasking.
    irq_event = |(chg_nxt & mask_nxt & ~(chg & mask));
    chg_rd  = 8'h00;
    mask_rd = 8'h00;
    chg_rd[N_REGS-1:0]  = chg;
    mask_rd[N_REGS-1:0] = mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= '0;
      primed <= 1'b0;
      chg    <= '0;
      mask   <= '0;
      irq_q  <= 1'b0;
    end else begin
      prev   <= host_in;
      primed <= 1'b1;
      chg    <= chg_nxt;
      mask   <= mask_nxt;
      irq_q  <= irq_event | (irq_q & ~Interrupt_Ack);
    end
  end

  assign Interrupt = irq_q;
`else
  logic unused_ack;

  assign chg_rd     = 8'h00;
  assign mask_rd    = 8'h00;
  assign Interrupt  = 1'b0;
  assign unused_ack = Interrupt_Ack;
`endif

endmodule

// File: tb/tb_pblaze_regfile_if.sv
// Directed bench for pblaze_regfile_if (N_REGS=4, BASE_ADDR=8'h10); expectations follow
// PBLAZE_REGFILE_IRQ_EN so the same bench serves both builds.
module tb_pblaze_regfile_if;

`ifdef PBLAZE_REGFILE_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [31:0] OUT_RST = 32'h4433_2211;

  logic        clk;
  logic        reset;
  logic        Wr_Strobe;
  logic        Rd_Strobe;
  logic [7:0]  AddrIn;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;
  logic        Interrupt;
  logic        Interrupt_Ack;
  logic [31:0] host_in;
  logic [31:0] host_out;
  logic [3:0]  host_out_stb;
  logic [3:0]  host_in_rd;

  int n_chk;
  int n_pass;
  logic [7:0] exp_q[$];

  pblaze_regfile_if #(
    .N_REGS   (4),
    .BASE_ADDR(8'h10),
    .OUT_RESET(OUT_RST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Wr_Strobe    (Wr_Strobe),
    .Rd_Strobe    (Rd_Strobe),
    .AddrIn       (AddrIn),
    .DataIn       (DataIn),
    .DataOut      (DataOut),
    .Interrupt    (Interrupt),
    .Interrupt_Ack(Interrupt_Ack),
    .host_in      (host_in),
    .host_out     (host_out),
    .host_out_stb (host_out_stb),
    .host_in_rd   (host_in_rd)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pb_write(input logic [7:0] addr, input logic [7:0] data);
    Wr_Strobe = 1'b1;
    AddrIn    = addr;
    DataIn    = data;
    tick();
    Wr_Strobe = 1'b0;
  endtask

  task automatic pb_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    Rd_Strobe = 1'b1;
    AddrIn    = addr;
    exp_q.push_back(exp);
    tick();
    Rd_Strobe = 1'b0;
    check(tag, DataOut, exp_q.pop_front());
  endtask

  task automatic ack_irq();
    Interrupt_Ack = 1'b1;
    tick();
    Interrupt_Ack = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    Wr_Strobe = 1'b0;
    Rd_Strobe = 1'b0;
    AddrIn = 8'h00;
    DataIn = 8'h00;
    Interrupt_Ack = 1'b0;
    host_in = 32'h0;
    tick();
    tick();
    check("rst_dataout", DataOut, 8'h00);
    check("rst_host_out", host_out, OUT_RST);
    check("rst_stb", host_out_stb, 4'b0000);
    check("rst_rd", host_in_rd, 4'b0000);
    check("rst_irq", Interrupt, 1'b0);
    reset = 1'b0;
    tick();
    tick();

    // write path, window hit and miss
    pb_write(8'h12, 8'hA5);
    check("wr_host_out", host_out, 32'h44A5_2211);
    check("wr_stb", host_out_stb, 4'b0100);
    tick();
    check("wr_stb_drop", host_out_stb, 4'b0000);
    pb_write(8'h22, 8'h77);
    check("miss_host_out", host_out, 32'h44A5_2211);
    check("miss_stb", host_out_stb, 4'b0000);
    pb_write(8'h12, 8'hA5);
    check("same_val_stb", host_out_stb, 4'b0100);

    // read path
    host_in = 32'h0000_3C00;
    pb_read("rd_byte1", 8'h11, 8'h3C);
    check("rd_strobe1", host_in_rd, 4'b0010);
    pb_read("rd_off7", 8'h17, 8'h00);
    check("rd_strobe_off7", host_in_rd, 4'b0000);
    pb_read("chg_byte1", 8'h14, IRQ ? 8'h02 : 8'h00);
    check("irq_masked_off", Interrupt, 1'b0);
    pb_write(8'h14, 8'h02);
    pb_read("chg_w1c", 8'h14, 8'h00);

    // simultaneous read and write on the same offset
    Wr_Strobe = 1'b1;
    Rd_Strobe = 1'b1;
    AddrIn = 8'h11;
    DataIn = 8'h99;
    tick();
    Wr_Strobe = 1'b0;
    Rd_Strobe = 1'b0;
    check("rw_host_out", host_out, 32'h44A5_9911);
    check("rw_stb", host_out_stb, 4'b0010);
    check("rw_rd", host_in_rd, 4'b0010);
    check("rw_dataout", DataOut, 8'h3C);

    // mask + change + ack
    pb_write(8'h15, 8'h01);
    pb_read("mask_rd", 8'h15, IRQ ? 8'h01 : 8'h00);
    host_in = 32'h0000_3C7F;
    tick();
    check("irq_set", Interrupt, IRQ);
    pb_read("chg_byte0", 8'h14, IRQ ? 8'h01 : 8'h00);
    check("irq_hold", Interrupt, IRQ);
    ack_irq();
    check("irq_ack", Interrupt, 1'b0);
    pb_write(8'h14, 8'h01);
    pb_read("chg_clear0", 8'h14, 8'h00);

    // unmask while already flagged; W1C racing a new change
    host_in = 32'h0055_3C7F;
    tick();
    check("irq_unmasked_chg", Interrupt, 1'b0);
    pb_read("chg_byte2", 8'h14, IRQ ? 8'h04 : 8'h00);
    pb_write(8'h15, 8'h04);
    check("irq_on_mask_wr", Interrupt, IRQ);
    ack_irq();
    check("irq_ack2", Interrupt, 1'b0);
    Wr_Strobe = 1'b1;
    AddrIn = 8'h14;
    DataIn = 8'h04;
    host_in = 32'h0066_3C7F;
    tick();
    Wr_Strobe = 1'b0;
    pb_read("set_beats_clr", 8'h14, IRQ ? 8'h04 : 8'h00);

    // clearing CHG does not drop Interrupt; ack racing a new event keeps it
    pb_write(8'h14, 8'h04);
    host_in = 32'h0077_3C7F;
    tick();
    check("irq_new_evt", Interrupt, IRQ);
    pb_write(8'h14, 8'h04);
    check("irq_after_w1c", Interrupt, IRQ);
    Interrupt_Ack = 1'b1;
    host_in = 32'h0088_3C7F;
    tick();
    Interrupt_Ack = 1'b0;
    check("irq_ack_vs_evt", Interrupt, IRQ);
    ack_irq();
    check("irq_ack3", Interrupt, 1'b0);

    // asynchronous reset in the middle of a write
    Wr_Strobe = 1'b1;
    AddrIn = 8'h13;
    DataIn = 8'hEE;
    #2;
    reset = 1'b1;
    #1;
    check("arst_host_out", host_out, OUT_RST);
    check("arst_dataout", DataOut, 8'h00);
    check("arst_stb", host_out_stb, 4'b0000);
    check("arst_irq", Interrupt, 1'b0);
    Wr_Strobe = 1'b0;
    tick();
    reset = 1'b0;
    pb_read("post_rst_chg_a", 8'h14, 8'h00);
    check("post_rst_stb", host_out_stb, 4'b0000);
    pb_read("post_rst_chg_b", 8'h14, 8'h00);
    pb_read("post_rst_mask", 8'h15, 8'h00);
    check("post_rst_host_out", host_out, OUT_RST);
    check("post_rst_irq", Interrupt, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
